// File: rtl/bip_control_unit.sv
// Control unit for the BIP accumulator processor: PC, IR and a FETCH/EXEC/WB/HALT sequencer
// with registered datapath strobes and a saturating run-cycle counter for the debug unit.
module bip_control_unit #(
    parameter int OPCODE_LENGTH  = 5,
    parameter int OPERAND_LENGTH = 11,
    parameter int PC_LENGTH      = 11,
    parameter int COUNT_LENGTH   = 32
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [OPCODE_LENGTH+OPERAND_LENGTH-1:0] instruction,
    output logic [PC_LENGTH-1:0]                    pc_addr,
    output logic [OPERAND_LENGTH-1:0]               operand,
    output logic                                    WrPC,
    output logic [1:0]                              SelA,
    output logic                                    SelB,
    output logic                                    WrAcc,
    output logic                                    Op,
    output logic                                    WrRam,
    output logic                                    RdRam,
    output logic                                    halted,
    output logic [COUNT_LENGTH-1:0]                 cycle_count
);
    localparam int INSTR_LENGTH = OPCODE_LENGTH + OPERAND_LENGTH;

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, HALT} state_t;

    typedef struct packed {
        logic [1:0] selA;
        logic       selB;
        logic       op;
        logic       wrAcc;
        logic       wrPc;
        logic       wrRam;
        logic       rdRam;
    } ctrl_t;

    state_t                   state;
    logic [PC_LENGTH-1:0]     pc;
    logic [INSTR_LENGTH-1:0]  ir;
    ctrl_t                    ctrl;
    logic [OPCODE_LENGTH-1:0] irOpcode;

    assign irOpcode = ir[INSTR_LENGTH-1 -: OPCODE_LENGTH];

    // Strobes for the EXEC cycle; undefined opcodes decode to no strobes, like HLT.
    function automatic ctrl_t decodeExec(input logic [OPCODE_LENGTH-1:0] opcode);
        ctrl_t c;
        c = '0;
        case (opcode)
            OPCODE_LENGTH'(1): begin c.wrRam = 1'b1; c.wrPc = 1'b1; end
            OPCODE_LENGTH'(2): begin c.rdRam = 1'b1; end
            OPCODE_LENGTH'(3): begin c.selA = 2'b01; c.wrAcc = 1'b1; c.wrPc = 1'b1; end
            OPCODE_LENGTH'(4): begin c.selA = 2'b10; c.rdRam = 1'b1; end
            OPCODE_LENGTH'(5): begin c.selA = 2'b10; c.selB = 1'b1; c.wrAcc = 1'b1; c.wrPc = 1'b1; end
            OPCODE_LENGTH'(6): begin c.selA = 2'b10; c.op = 1'b1; c.rdRam = 1'b1; end
            OPCODE_LENGTH'(7): begin c.selA = 2'b10; c.selB = 1'b1; c.op = 1'b1; c.wrAcc = 1'b1; c.wrPc = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic readsRam(input logic [OPCODE_LENGTH-1:0] opcode);
        return (opcode == OPCODE_LENGTH'(2)) || (opcode == OPCODE_LENGTH'(4)) ||
               (opcode == OPCODE_LENGTH'(6));
    endfunction

    function automatic logic haltsOn(input logic [OPCODE_LENGTH-1:0] opcode);
        return (opcode == '0) || (opcode > OPCODE_LENGTH'(7));
    endfunction

    function automatic logic [COUNT_LENGTH-1:0] satInc(input logic [COUNT_LENGTH-1:0] v);
        return (v == '1) ? v : v + COUNT_LENGTH'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            ir          <= '0;
            ctrl        <= '0;
            halted      <= 1'b0;
            cycle_count <= '0;
        end else begin
            ctrl <= '0;
            if (ctrl.wrPc) pc <= pc + PC_LENGTH'(1);
            case (state)
                IDLE: begin
                    if (start) begin
                        cycle_count <= '0;
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    cycle_count <= satInc(cycle_count);
                    ir          <= instruction;
                    ctrl        <= decodeExec(instruction[INSTR_LENGTH-1 -: OPCODE_LENGTH]);
                    state       <= EXEC;
                end
                EXEC: begin
                    cycle_count <= satInc(cycle_count);
                    if (readsRam(irOpcode)) begin
                        // RAM data arrives now; keep the ALU/mux setup and capture it.
                        ctrl  <= '{selA: ctrl.selA, selB: ctrl.selB, op: ctrl.op,
                                   wrAcc: 1'b1, wrPc: 1'b1, wrRam: 1'b0, rdRam: 1'b0};
                        state <= WB;
                    end else if (haltsOn(irOpcode)) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        state <= FETCH;
                    end
                end
                WB: begin
                    cycle_count <= satInc(cycle_count);
                    state       <= FETCH;
                end
                HALT: begin
                    if (start) begin
                        pc          <= '0;
                        cycle_count <= '0;
                        halted      <= 1'b0;
                        state       <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pc_addr = pc;
    assign operand = ir[OPERAND_LENGTH-1:0];
    assign WrPC    = ctrl.wrPc;
    assign SelA    = ctrl.selA;
    assign SelB    = ctrl.selB;
    assign WrAcc   = ctrl.wrAcc;
    assign Op      = ctrl.op;
    assign WrRam   = ctrl.wrRam;
    assign RdRam   = ctrl.rdRam;
endmodule

// File: tb/tb_bip_control_unit.sv
// Bench for bip_control_unit: opcode table, reference programs and random programs checked
// cycle by cycle against an instruction-level model, plus a narrow instance for PC wrap.
module tb_bip_control_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start;
    logic [15:0] instruction;
    logic [10:0] pc_addr, operand;
    logic        WrPC, SelB, WrAcc, Op, WrRam, RdRam, halted;
    logic [1:0]  SelA;
    logic [31:0] cycle_count;
    logic [15:0] rom [2048];
    assign instruction = rom[pc_addr];

    bip_control_unit dut (
        .clk(clk), .rst(rst), .start(start), .instruction(instruction),
        .pc_addr(pc_addr), .operand(operand), .WrPC(WrPC), .SelA(SelA), .SelB(SelB),
        .WrAcc(WrAcc), .Op(Op), .WrRam(WrRam), .RdRam(RdRam), .halted(halted),
        .cycle_count(cycle_count)
    );

    logic        rst2, start2;
    logic [15:0] instruction2;
    logic [1:0]  pcAddr2;
    logic [10:0] operand2;
    logic        wrPc2, selB2, wrAcc2, op2, wrRam2, rdRam2, halted2;
    logic [1:0]  selA2;
    logic [3:0]  count2;
    logic [15:0] rom2 [4];
    assign instruction2 = rom2[pcAddr2];

    bip_control_unit #(.PC_LENGTH(2), .COUNT_LENGTH(4)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .instruction(instruction2),
        .pc_addr(pcAddr2), .operand(operand2), .WrPC(wrPc2), .SelA(selA2), .SelB(selB2),
        .WrAcc(wrAcc2), .Op(op2), .WrRam(wrRam2), .RdRam(rdRam2), .halted(halted2),
        .cycle_count(count2)
    );

    typedef struct packed {
        logic [10:0] pcAddr;
        logic [10:0] operand;
        logic        wrPc;
        logic [1:0]  selA;
        logic        selB;
        logic        wrAcc;
        logic        op;
        logic        wrRam;
        logic        rdRam;
        logic        halted;
        logic [31:0] cnt;
    } obs_t;

    obs_t act;
    assign act = {pc_addr, operand, WrPC, SelA, SelB, WrAcc, Op, WrRam, RdRam, halted, cycle_count};

    typedef struct packed {
        logic [4:0] opc;
        logic [1:0] selA;
        logic       selB;
        logic       op;
        logic       wrAcc;
        logic       wrPc;
        logic       wrRam;
        logic       rdRam;
        logic       hasWb;
        logic       halts;
    } opRow_t;

    opRow_t      tbl [10];
    obs_t        expQ [$];
    logic [15:0] mIr;
    int          checks = 0;
    int          failures = 0;

    function automatic void check(input string name, input logic [63:0] actual,
                                  input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, actual, required);
        end
    endfunction

    function automatic opRow_t lookup(input logic [4:0] opc);
        opRow_t r;
        r = '0;
        r.opc = opc;
        r.halts = 1'b1;
        for (int i = 0; i < 10; i++)
            if (tbl[i].opc == opc) r = tbl[i];
        return r;
    endfunction

    // Instruction-level interpretation of the program in rom, expanded into per-cycle outputs.
    function automatic void buildTrace();
        logic [10:0] pc;
        logic [31:0] cnt;
        obs_t        e;
        opRow_t      r;
        pc = '0;
        cnt = '0;
        expQ.delete();
        for (int n = 0; n < 64; n++) begin
            e = '0; e.pcAddr = pc; e.operand = mIr[10:0]; e.cnt = cnt;
            expQ.push_back(e);
            cnt++;
            mIr = rom[pc];
            r = lookup(mIr[15:11]);
            e = '0; e.pcAddr = pc; e.operand = mIr[10:0]; e.cnt = cnt;
            e.wrPc = r.wrPc; e.selA = r.selA; e.selB = r.selB; e.wrAcc = r.wrAcc;
            e.op = r.op; e.wrRam = r.wrRam; e.rdRam = r.rdRam;
            expQ.push_back(e);
            cnt++;
            if (r.halts) begin
                e = '0; e.pcAddr = pc; e.operand = mIr[10:0]; e.halted = 1'b1; e.cnt = cnt;
                expQ.push_back(e);
                break;
            end
            if (r.hasWb) begin
                e.rdRam = 1'b0; e.wrAcc = 1'b1; e.wrPc = 1'b1; e.cnt = cnt;
                expQ.push_back(e);
                cnt++;
            end
            pc = pc + 11'd1;
        end
    endfunction

    task automatic clearRom();
        for (int i = 0; i < 2048; i++) rom[i] = '0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mIr = '0;
    endtask

    task automatic runProgram(input string name, input bit noisy);
        buildTrace();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < expQ.size(); i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("%s_cyc%0d", name, i + 1), 64'(act), 64'(expQ[i]));
            start = (noisy && i != expQ.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        obs_t        e;
        int          len;
        logic [4:0]  hop;
        logic [7:0]  strobes2;
        logic [7:0]  ldiStrobes;

        clearRom();
        for (int i = 0; i < 4; i++) rom2[i] = '0;
        rst = 1'b1; start = 1'b0; rst2 = 1'b1; start2 = 1'b0; mIr = '0;
        tbl[0] = '{5'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{5'h01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{5'h02, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{5'h03, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{5'h04, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{5'h05, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{5'h06, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{5'h07, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{5'h08, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9] = '{5'h1f, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset then idle with start low
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_values", 64'(act), 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("idle%0d", i), 64'(act), 64'd0);
        end

        // Opcode table: single instruction followed by HLT
        for (int k = 0; k < 10; k++) begin
            clearRom();
            rom[0] = {tbl[k].opc, 11'($urandom_range(0, 2047))};
            runProgram($sformatf("op%02h", tbl[k].opc), 1'b0);
        end

        // LDI 5; ADDI 3; STO 7; HLT
        clearRom();
        rom[0] = {5'd3, 11'd5}; rom[1] = {5'd5, 11'd3}; rom[2] = {5'd1, 11'd7}; rom[3] = '0;
        runProgram("prog_ldi", 1'b0);
        check("prog_ldi_count", 64'(cycle_count), 64'd8);
        check("prog_ldi_pc", 64'(pc_addr), 64'd3);
        check("prog_ldi_halted", 64'(halted), 64'd1);

        // LD 2; SUB 4; HLT, started from HALT with PC at 3
        clearRom();
        rom[0] = {5'd2, 11'd2}; rom[1] = {5'd6, 11'd4};
        runProgram("prog_ld", 1'b0);
        check("prog_ld_count", 64'(cycle_count), 64'd8);

        // Undefined opcode, then restart from HALT
        clearRom();
        rom[0] = {5'h1f, 11'h123};
        runProgram("undef", 1'b0);
        check("undef_count", 64'(cycle_count), 64'd2);
        runProgram("undef_restart", 1'b0);
        check("undef_restart_count", 64'(cycle_count), 64'd2);

        // Random programs with start noise while running
        for (int r = 0; r < 20; r++) begin
            clearRom();
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++)
                rom[i] = {5'($urandom_range(1, 7)), 11'($urandom_range(0, 2047))};
            hop = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(8, 31));
            rom[len] = {hop, 11'($urandom_range(0, 2047))};
            runProgram($sformatf("rand%0d", r), 1'b1);
        end

        // Reset during WB of ADD with start held high
        doReset();
        clearRom();
        rom[0] = {5'd4, 11'd9};
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rstwb_exec_rdram", 64'(RdRam), 64'd1);
        @(negedge clk);
        check("rstwb_wb_wracc", 64'(WrAcc), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstwb_reset", 64'(act), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rstwb_fetch", 64'(act), 64'd0);
        @(negedge clk);
        e = '0; e.operand = 11'd9; e.selA = 2'b10; e.rdRam = 1'b1; e.cnt = 32'd1;
        check("rstwb_exec_again", 64'(act), 64'(e));
        start = 1'b0;
        doReset();

        // Narrow instance: PC wrap with four LDI, HLT placed at address 0 for the second pass
        for (int i = 0; i < 4; i++) rom2[i] = {5'd3, 11'(i + 1)};
        @(negedge clk);
        rst2 = 1'b0;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        ldiStrobes = {1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int c = 1; c <= 10; c++) begin
            strobes2 = {wrPc2, selA2, selB2, wrAcc2, op2, wrRam2, rdRam2};
            check($sformatf("wrap_pc_c%0d", c), 64'(pcAddr2), 64'(((c - 1) / 2) % 4));
            check($sformatf("wrap_strobes_c%0d", c), 64'(strobes2),
                  64'((c % 2 == 0 && c < 10) ? ldiStrobes : 8'd0));
            if (c == 2) rom2[0] = '0;
            @(negedge clk);
        end
        check("wrap_halted", 64'(halted2), 64'd1);
        check("wrap_count", 64'(count2), 64'd10);
        check("wrap_pc_final", 64'(pcAddr2), 64'd0);
        check("wrap_operand_final", 64'(operand2), 64'd0);

        // Restart from HALT with an endless LDI loop to saturate the 4-bit counter
        rom2[0] = {5'd3, 11'd1};
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("sat_restart_pc", 64'(pcAddr2), 64'd0);
        check("sat_restart_count", 64'(count2), 64'd0);
        repeat (20) @(negedge clk);
        check("sat_count", 64'(count2), 64'd15);
        rst2 = 1'b1;
        @(negedge clk);
        check("sat_reset_count", 64'(count2), 64'd0);
        rst2 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bip_control_unit.md
# bip_control_unit

Sequential control unit for the BIP accumulator processor, successor to the purely combinational opcode decoder. It owns the program counter, the instruction register and a fetch/execute state machine, and drives the datapath and data-RAM strobes for each instruction. Opcode, operand and PC widths are parameters. It adds a write-back cycle for RAM-reading instructions, an explicit halt/restart protocol and a run-cycle counter for the debug unit.

## Interface
- OPCODE_LENGTH, 5, opcode field width (instruction MSBs)
- OPERAND_LENGTH, 11, operand/immediate field width (instruction LSBs)
- PC_LENGTH, 11, program counter width
- COUNT_LENGTH, 32, run-cycle counter width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  run request; sampled in IDLE and HALT only
- instruction  in  OPCODE_LENGTH+OPERAND_LENGTH  program memory read data, valid one cycle after pc_addr changes
- pc_addr  out  PC_LENGTH  program memory address = PC register
- operand  out  OPERAND_LENGTH  IR operand field (data-RAM address / immediate)
- WrPC  out  1  PC advances at this edge
- SelA  out  2  accumulator source: 00 RAM data, 01 immediate, 10 ALU result
- SelB  out  1  ALU B operand: 0 RAM data, 1 immediate
- WrAcc  out  1  accumulator write enable
- Op  out  1  ALU op: 0 add, 1 subtract
- WrRam  out  1  data-RAM write (accumulator to RAM[operand])
- RdRam  out  1  data-RAM read request (synchronous RAM, data next cycle)
- halted  out  1  processor stopped by HLT or undefined opcode
- cycle_count  out  COUNT_LENGTH  cycles spent in FETCH/EXEC/WB since last start

## Operation
- States: IDLE, FETCH, EXEC, WB, HALT.
- IDLE: all strobes 0; start=1 -> FETCH, cycle_count <= 0.
- FETCH: one cycle; IR <= instruction at its end; -> EXEC.
- EXEC, decoded from IR opcode:
  - HLT (00000): no strobes; -> HALT, halted <= 1; PC not advanced.
  - STO (00001): WrRam=1, WrPC=1; -> FETCH.
  - LD (00010): RdRam=1, SelA=00; -> WB.
  - LDI (00011): SelA=01, WrAcc=1, WrPC=1; -> FETCH.
  - ADD (00100): RdRam=1, SelA=10, SelB=0, Op=0; -> WB.
  - ADDI (00101): SelA=10, SelB=1, Op=0, WrAcc=1, WrPC=1; -> FETCH.
  - SUB (00110): RdRam=1, SelA=10, SelB=0, Op=1; -> WB.
  - SUBI (00111): SelA=10, SelB=1, Op=1, WrAcc=1, WrPC=1; -> FETCH.
  - any other opcode: treated as HLT.
- WB (LD/ADD/SUB only): SelA/SelB/Op held from EXEC, RdRam=0, WrAcc=1, WrPC=1; -> FETCH.
- When WrPC=1, PC <= PC+1 modulo 2^PC_LENGTH (wraps from all-ones to 0, no flag).
- HALT: all strobes 0, PC, IR and cycle_count held; start=1 -> PC <= 0, cycle_count <= 0, halted <= 0, -> FETCH.
- start in FETCH/EXEC/WB is ignored.
- cycle_count increments each cycle in FETCH, EXEC, WB; saturates at all-ones; held in IDLE/HALT.
- Strobes are Moore outputs of state and IR; never asserted in IDLE, FETCH or HALT.
- operand always equals IR[OPERAND_LENGTH-1:0].

## Timing
- Reset values: state IDLE, PC 0, IR 0, pc_addr 0, operand 0, all strobes 0, SelA 00, halted 0, cycle_count 0.
- rst wins over start and any state; the cycle after rst shows reset values regardless of the state it interrupted.
- Non-RAM-reading instructions: 2 cycles (FETCH, EXEC). LD/ADD/SUB: 3 cycles (FETCH, EXEC, WB). HLT: 2 cycles, then HALT.
- start accepted at edge N -> FETCH during cycle N+1, first IR load at edge N+1.
- halted rises on the edge leaving EXEC of HLT; cycle_count then stops.
- Data RAM sees address=operand with RdRam in EXEC; returns data in WB, where WrAcc captures it.

## Test plan
- Reset then idle: rst 1 cycle, start=0 for 10 cycles -> all outputs at reset values, cycle_count 0, pc_addr 0.
- Program LDI 5; ADDI 3; STO 7; HLT with start pulse -> WrAcc in cycles 2 and 4, WrRam with operand 7 in cycle 6, halted=1 after cycle 8, cycle_count 8, pc_addr 3.
- LD 2; SUB 4; HLT -> RdRam then WrAcc with SelA 00 (LD), RdRam then WrAcc with SelA 10/SelB 0/Op 1 (SUB); cycle_count 8.
- Undefined opcode 11111 at address 0 -> no strobes, halted=1, cycle_count 2; start in HALT -> pc_addr 0, cycle_count restarts from 0.
- PC wrap with PC_LENGTH=2: four LDI then HLT fetched at address 0 again -> pc_addr sequence 0,1,2,3,0, no spurious strobes.
- rst asserted during WB of ADD, start held high throughout -> WrAcc not asserted after reset, state IDLE, then FETCH on next cycle because start=1.
